tl_traffic_sensor: RTL and testbench

TL_TRAFFIC_SENSOR -- requirements
Module: tl_traffic_sensor

---
 rtl/tl_pkg.sv | 16 +
 rtl/tl_lane_queue.sv | 88 ++++++++
 rtl/tl_traffic_sensor.sv | 61 ++++++
 tb/tb_tl_traffic_sensor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Light codes and queue-depth type shared by the traffic sensor and the traffic light controller.
// No logic here, so no latency and no flow control.
package tl_pkg;

   typedef logic [1:0] light_t;

   localparam light_t GREEN  = 2'b00;
   localparam light_t YELLOW = 2'b01;
   localparam light_t RED    = 2'b10;
   localparam light_t LEFT   = 2'b11;

   typedef logic [3:0] qdepth_t;

   localparam qdepth_t Q_MAX = 4'd15;

endpackage

// File: rtl/tl_lane_queue.sv
// One lane: detector sync + debounce, arrival edge, pass timer, saturating queue and sticky overflow.
// Detector to queue takes DEB_CYCLES+3 edges; there is no backpressure, and arrivals at a full queue are dropped.
module tl_lane_queue
   import tl_pkg::*;
#(
   parameter int DEB_CYCLES  = 3,
   parameter int PASS_CYCLES = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    det,
   input  logic    svc,
   output qdepth_t q,
   output logic    ovf
);

   localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
   localparam logic [3:0] PASS_LAST = 4'(PASS_CYCLES - 1);

   logic       sync1, sync2;
   logic       deb, deb_d;
   logic [3:0] stab_cnt;
   logic [3:0] pass_tmr;
   logic       arr, dis;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= det;
         sync2 <= sync1;
      end
   end

   // A sample that matches the current level restarts the stability count.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb      <= 1'b0;
         deb_d    <= 1'b0;
         stab_cnt <= 4'd0;
      end else begin
         deb_d <= deb;
         if (sync2 != deb) begin
            if (stab_cnt == DEB_LAST) begin
               deb      <= sync2;
               stab_cnt <= 4'd0;
            end else begin
               stab_cnt <= stab_cnt + 4'd1;
            end
         end else begin
            stab_cnt <= 4'd0;
         end
      end
   end

   assign arr = deb & ~deb_d;
   assign dis = svc && (q != 4'd0) && (pass_tmr == PASS_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         pass_tmr <= 4'd0;
      end else if (svc && (q != 4'd0)) begin
         if (pass_tmr == PASS_LAST) pass_tmr <= 4'd0;
         else                       pass_tmr <= pass_tmr + 4'd1;
      end else begin
         pass_tmr <= 4'd0;
      end
   end

   // Simultaneous arrival and discharge cancel out.
   always_ff @(posedge clk) begin
      if (reset) begin
         q   <= 4'd0;
         ovf <= 1'b0;
      end else begin
         unique case ({arr, dis})
            2'b10: begin
               if (q == Q_MAX) ovf <= 1'b1;
               else            q   <= q + 4'd1;
            end
            2'b01:   q <= q - 4'd1;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/tl_traffic_sensor.sv
// Four-lane vehicle queue tracker producing traffic requests for the light controller.
// Detector to T output takes DEB_CYCLES+3 edges; no backpressure, full queues drop arrivals and flag ovf.
module tl_traffic_sensor
   import tl_pkg::*;
#(
   parameter int DEB_CYCLES  = 3,
   parameter int PASS_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       det_a,
   input  logic       det_al,
   input  logic       det_b,
   input  logic       det_bl,
   input  logic [1:0] La,
   input  logic [1:0] Lb,
   output logic       Ta,
   output logic       Tal,
   output logic       Tb,
   output logic       Tbl,
   output logic [3:0] q_a,
   output logic [3:0] q_al,
   output logic [3:0] q_b,
   output logic [3:0] q_bl,
   output logic [3:0] ovf
);

   logic [3:0] det;
   logic [3:0] svc;
   qdepth_t    q [4];
   logic [3:0] lane_ovf;

   assign det = {det_bl, det_b, det_al, det_a};
   assign svc = {Lb == LEFT, Lb == GREEN, La == LEFT, La == GREEN};

   for (genvar i = 0; i < 4; i++) begin : g_lane
      tl_lane_queue #(
         .DEB_CYCLES  (DEB_CYCLES),
         .PASS_CYCLES (PASS_CYCLES)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .det   (det[i]),
         .svc   (svc[i]),
         .q     (q[i]),
         .ovf   (lane_ovf[i])
      );
   end

   assign q_a  = q[0];
   assign q_al = q[1];
   assign q_b  = q[2];
   assign q_bl = q[3];
   assign ovf  = lane_ovf;

   assign Ta  = (q[0] != 4'd0);
   assign Tal = (q[1] != 4'd0);
   assign Tb  = (q[2] != 4'd0);
   assign Tbl = (q[3] != 4'd0);

endmodule

// File: tb/tb_tl_traffic_sensor.sv
// Directed bench for tl_traffic_sensor with default parameters.
module tb_tl_traffic_sensor;

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;
   localparam logic [1:0] LEFT   = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] det;
   logic [1:0] La, Lb;
   logic       Ta, Tal, Tb, Tbl;
   logic [3:0] q_a, q_al, q_b, q_bl, ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tl_traffic_sensor dut (
      .clk    (clk),
      .reset  (reset),
      .det_a  (det[0]),
      .det_al (det[1]),
      .det_b  (det[2]),
      .det_bl (det[3]),
      .La     (La),
      .Lb     (Lb),
      .Ta     (Ta),
      .Tal    (Tal),
      .Tb     (Tb),
      .Tbl    (Tbl),
      .q_a    (q_a),
      .q_al   (q_al),
      .q_b    (q_b),
      .q_bl   (q_bl),
      .ovf    (ovf)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Clean pulse: arrival lands on the 6th edge after rise, then allow the fall to settle.
   task automatic arrive(input int lane);
      det[lane] = 1'b1;
      step(6);
      det[lane] = 1'b0;
      step(6);
   endtask

   initial begin
      reset = 1'b1;
      det   = 4'b0000;
      La    = RED;
      Lb    = RED;
      step(2);
      reset = 1'b0;
      check("reset_qa", q_a, 0);
      check("reset_qal", q_al, 0);
      check("reset_qb", q_b, 0);
      check("reset_qbl", q_bl, 0);
      check("reset_T", {Ta, Tal, Tb, Tbl}, 0);
      check("reset_ovf", ovf, 0);

      // Latency: det_a rises after edge 1, Ta and q_a become 1 at edge 7.
      step(1);
      det[0] = 1'b1;
      step(5);
      check("lat_qa_e6", q_a, 0);
      check("lat_Ta_e6", Ta, 0);
      step(1);
      check("lat_qa_e7", q_a, 1);
      check("lat_Ta_e7", Ta, 1);
      step(3);
      check("lat_qa_hold", q_a, 1);
      check("lat_Ta_hold", Ta, 1);
      det[0] = 1'b0;
      step(8);
      check("lat_qa_fall", q_a, 1);

      // Two-cycle glitch on det_al is filtered.
      det[1] = 1'b1;
      step(2);
      det[1] = 1'b0;
      step(10);
      check("glitch_qal", q_al, 0);
      check("glitch_Tal", Tal, 0);

      // Lane b discharge timing, yellow holds.
      arrive(2);
      arrive(2);
      check("qb_two", q_b, 2);
      Lb = YELLOW;
      step(3);
      check("qb_yellow", q_b, 2);
      Lb = GREEN;
      step(1);
      check("qb_g1", q_b, 2);
      step(1);
      check("qb_g2", q_b, 1);
      check("Tb_g2", Tb, 1);
      step(2);
      check("qb_g4", q_b, 0);
      check("Tb_g4", Tb, 0);
      Lb = RED;
      step(1);

      // Saturation and sticky overflow on lane bl.
      for (int i = 0; i < 15; i++) arrive(3);
      check("qbl_full", q_bl, 15);
      check("ovf_before", ovf, 0);
      arrive(3);
      check("qbl_sat", q_bl, 15);
      check("ovf_set", ovf, 4'b1000);
      Lb = LEFT;
      step(40);
      check("qbl_drain", q_bl, 0);
      check("Tbl_drain", Tbl, 0);
      check("ovf_sticky", ovf, 4'b1000);
      Lb = RED;
      step(1);

      // Arrival coinciding with discharge leaves q_a unchanged (q_a=1 already, add 2).
      arrive(0);
      arrive(0);
      check("qa_three", q_a, 3);
      det[0] = 1'b1;
      step(4);
      La = GREEN;
      step(1);
      check("coinc_pre", q_a, 3);
      step(1);
      check("coinc_edge", q_a, 3);
      La = RED;
      step(1);
      check("coinc_post", q_a, 3);
      det[0] = 1'b0;
      step(8);
      check("coinc_settle", q_a, 3);

      // Reset mid-discharge with q_a=4; det_b held high across reset release.
      arrive(0);
      check("qa_four", q_a, 4);
      La = GREEN;
      step(1);
      reset  = 1'b1;
      det[2] = 1'b1;
      step(1);
      check("rst_qa", q_a, 0);
      check("rst_qs", {q_al, q_b, q_bl}, 0);
      check("rst_T", {Ta, Tal, Tb, Tbl}, 0);
      check("rst_ovf", ovf, 0);
      reset = 1'b0;
      La    = RED;
      step(10);
      check("post_rst_qb", q_b, 1);
      check("post_rst_Tb", Tb, 1);
      det[2] = 1'b0;
      step(10);
      check("post_rst_qb_once", q_b, 1);
      check("post_rst_qa", q_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
